// File: rtl/tt_um_crc3_check.sv
// tt_um_crc3_check: serial CRC-3 (x^3 + x + 1) frame checker.
// Receives 5 message bits then 3 CRC bits MSB-first on ui_in[1], framed by
// ui_in[0]. Latches the recovered message, a pass/fail verdict and a sticky
// error flag.
// Optional feature: define CRC3_CHECK_COUNTERS_EN to build the saturating
// good/bad frame counters driven onto uio_out.
module tt_um_crc3_check (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] idx;
    logic [4:0] msg;
    logic [4:0] msg_out;
    logic [2:0] lfsr;
    logic [2:0] rxcrc;
    logic       frame_done;
    logic       crc_ok;
    logic       sticky_err;

    logic       strobe;
    logic       din;
    logic       clr;
    logic       take;
    logic       last;
    logic       leave;
    logic       lfsr_in;
    logic [2:0] lfsr_next;
    logic       ok;
    logic       unused;

    assign strobe = ui_in[0];
    assign din    = ui_in[1];
    assign clr    = ena & ui_in[2];
    assign unused = &{1'b0, uio_in, ui_in[7:3]};

    // CRC bits are clocked into the LFSR as zeros; message bits feed it directly.
    assign lfsr_in   = (idx < 3'd5) ? din : 1'b0;
    assign lfsr_next = {lfsr_in ^ lfsr[2] ^ lfsr[0], lfsr[2:1]};
    assign ok        = (lfsr_next == {rxcrc[1:0], din});

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        last       = 1'b0;
        leave      = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        take       = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        take = 1'b1;
                        if (idx == 3'd7) begin
                            last       = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!strobe) begin
                        leave      = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bit shifting, LFSR, verdict and message latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 3'd0;
            msg        <= 5'd0;
            msg_out    <= 5'd0;
            lfsr       <= 3'd0;
            rxcrc      <= 3'd0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
        end else begin
            if (take) begin
                idx  <= idx + 3'd1;
                lfsr <= lfsr_next;
                if (idx < 3'd5) begin
                    msg <= {msg[3:0], din};
                end else begin
                    rxcrc <= {rxcrc[1:0], din};
                end
            end
            if (last) begin
                msg_out    <= msg;
                crc_ok     <= ok;
                frame_done <= 1'b1;
            end
            if (leave) begin
                frame_done <= 1'b0;
                crc_ok     <= 1'b0;
                lfsr       <= 3'd0;
                idx        <= 3'd0;
                rxcrc      <= 3'd0;
            end
        end
    end

    // Sticky error: set by a failed frame, cleared by clear (clear wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_err <= 1'b0;
        end else if (clr) begin
            sticky_err <= 1'b0;
        end else if (last && !ok) begin
            sticky_err <= 1'b1;
        end
    end

    assign uo_out = {sticky_err, crc_ok, frame_done, msg_out};

`ifdef CRC3_CHECK_COUNTERS_EN
    logic [3:0] good_cnt;
    logic [3:0] bad_cnt;

    // Saturating frame counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= 4'd0;
            bad_cnt  <= 4'd0;
        end else if (clr) begin
            good_cnt <= 4'd0;
            bad_cnt  <= 4'd0;
        end else if (last) begin
            if (ok) begin
                if (good_cnt != 4'd15) good_cnt <= good_cnt + 4'd1;
            end else begin
                if (bad_cnt != 4'd15) bad_cnt <= bad_cnt + 4'd1;
            end
        end
    end

    assign uio_out = {bad_cnt, good_cnt};
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_crc3_check.sv
// tb_tt_um_crc3_check: directed-vector bench for the serial CRC-3 checker.
// Expected values are hand-computed from the LFSR definition.
module tb_tt_um_crc3_check;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run;
    int tests_failed;

    tt_um_crc3_check dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Expected uio_out for the given counter values in the current build.
    function automatic logic [7:0] uio_exp(input logic [3:0] good, input logic [3:0] bad);
`ifdef CRC3_CHECK_COUNTERS_EN
        return {bad, good};
`else
        return 8'h00;
`endif
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ui_in = {6'b0, b, 1'b1};
        tick();
    endtask

    task automatic send_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic idle_cycle();
        ui_in = 8'h00;
        tick();
    endtask

    localparam logic [7:0] GOOD_A = 8'b10110_011;  // message 10110, CRC 011
    localparam logic [7:0] BAD_A  = 8'b10110_010;  // last CRC bit flipped
    localparam logic [7:0] GOOD_B = 8'b11001_110;  // message 11001, CRC 110

    initial begin
        logic [7:0] f;
        tests_run    = 0;
        tests_failed = 0;
        uio_in       = 8'h00;
        ena          = 1'b1;
        rst_n        = 1'b0;
        ui_in        = 8'($urandom);

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            ui_in = 8'($urandom);
            tick();
        end
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h00);
        ui_in = 8'h00;
        rst_n = 1'b1;
        tick();
`ifdef CRC3_CHECK_COUNTERS_EN
        check("uio_oe", uio_oe, 8'hFF);
`else
        check("uio_oe", uio_oe, 8'h00);
`endif
        check("idle_uo", uo_out, 8'h00);

        // Good frame.
        send_frame(GOOD_A);
        check("good_uo", uo_out, 8'h76);
        check("good_cnt", uio_out, uio_exp(4'd1, 4'd0));
        send_bit(1'b0);
        check("done_hold", uo_out, 8'h76);
        idle_cycle();
        check("good_release", uo_out, 8'h16);

        // Corrupt frame.
        send_frame(BAD_A);
        check("bad_uo", uo_out, 8'hB6);
        check("bad_cnt", uio_out, uio_exp(4'd1, 4'd1));
        idle_cycle();
        check("bad_release", uo_out, 8'h96);

        // Clear while idle.
        ui_in = 8'h04;
        tick();
        check("clear_uo", uo_out, 8'h16);
        check("clear_cnt", uio_out, uio_exp(4'd0, 4'd0));

        // All-zero frame with a strobe pause and ena gating.
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            ui_in = 8'h02;              // strobe low, data high
            tick();
        end
        check("pause_uo", uo_out, 8'h16);
        send_bit(1'b0);
        send_bit(1'b0);
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ui_in = 8'h07;              // strobe, data high, clear: all ignored
            tick();
        end
        ena = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        check("pause_frame_uo", uo_out, 8'h60);
        check("pause_frame_cnt", uio_out, uio_exp(4'd1, 4'd0));
        ena   = 1'b0;
        ui_in = 8'h00;
        tick();
        check("ena_hold_done", uo_out, 8'h60);
        ena = 1'b1;
        idle_cycle();
        check("pause_release", uo_out, 8'h00);

        // Saturation of the good counter.
        for (int n = 0; n < 13; n++) begin
            send_frame(GOOD_A);
            idle_cycle();
        end
        check("sat_mid_cnt", uio_out, uio_exp(4'd14, 4'd0));
        for (int n = 0; n < 4; n++) begin
            send_frame(GOOD_A);
            idle_cycle();
        end
        check("sat_cnt", uio_out, uio_exp(4'd15, 4'd0));
        check("sat_uo", uo_out, 8'h16);

        // Bad frame with clear on the bit-7 edge.
        f = BAD_A;
        for (int i = 7; i >= 1; i--) send_bit(f[i]);
        ui_in = 8'h05;                  // strobe, data 0, clear
        tick();
        check("clear_bit7_uo", uo_out, 8'h36);
        check("clear_bit7_cnt", uio_out, uio_exp(4'd0, 4'd0));
        idle_cycle();
        check("clear_bit7_release", uo_out, 8'h16);

        // Reset mid-frame, then a fresh good frame.
        f = GOOD_B;
        for (int i = 7; i >= 3; i--) send_bit(f[i]);
        rst_n = 1'b0;
        #1;
        check("midreset_uo", uo_out, 8'h00);
        check("midreset_uio", uio_out, 8'h00);
        tick();
        ui_in = 8'h00;
        rst_n = 1'b1;
        tick();
        send_frame(GOOD_B);
        check("after_reset_uo", uo_out, 8'h79);
        check("after_reset_cnt", uio_out, uio_exp(4'd1, 4'd0));
        idle_cycle();
        check("after_reset_release", uo_out, 8'h19);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
